// File: rtl/fp_add_pipe.sv
// ---------------------------------------------------------------------------
// fp_add_pipe -- pipelined floating-point adder (BF16 by default).
//
// Three register stages with valid/ready flow control:
//   S1 align   : unpack, classify, swap by magnitude, align the smaller
//                significand into a {hidden, mantissa, guard, round, sticky}
//                field.
//   S2 add/norm: add or subtract the significands, then renormalise.
//   S3 round   : round-to-nearest-even, detect overflow/underflow, pack.
// Special operands (NaN, inf) are resolved in S1 and carried down the pipe.
// Subnormal inputs are flushed to zero, with their sign kept.
//
// Optional feature: define FP_ADD_SAT_EN to saturate a finite-operand
// overflow to the largest finite magnitude instead of producing inf.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  operand handshake; in_ready = advance (combinational)
//   a, b               operands, W = 1+EXP_W+MAN_W bits
//   out_valid/out_ready result handshake
//   sum                registered rounded result
//   flags              {invalid, overflow, underflow, inexact}, aligned to sum
// ---------------------------------------------------------------------------
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic [3:0]   flags
);

    localparam int SIG_W   = MAN_W + 4;            // hidden + mantissa + G/R/S
    localparam int CNT_W   = $clog2(SIG_W + 1);
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    // Two spare bits: one for headroom above EXP_MAX, one for the sign.
    typedef logic signed [EXP_W+1:0] sexp_t;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [CNT_W-1:0] lzc(input logic [SIG_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = CNT_W'(SIG_W);
        // The highest set bit is visited last and therefore wins.
        for (int i = 0; i < SIG_W; i++) begin
            if (v[i]) cnt = CNT_W'(SIG_W - 1 - i);
        end
        return cnt;
    endfunction

    // All stages move together; a bubble still occupies its slot.
    logic advance;
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // ------------------------------------------------------------------ S1
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;

    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);
    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);

    // Flushed subnormals compare as magnitude zero.
    logic [W-2:0] mag_a, mag_b;
    logic         a_big;
    assign mag_a = a_zero ? '0 : a[W-2:0];
    assign mag_b = b_zero ? '0 : b[W-2:0];
    assign a_big = (mag_a >= mag_b);

    logic             sign_l;
    logic [EXP_W-1:0] exp_l, exp_s, diff;
    logic [SIG_W-1:0] sig_l, sig_s, sig_s_al;
    logic [2*SIG_W-1:0] ext;
    logic             any_nan, any_inf;

    always_comb begin
        sign_l = a_big ? sa : sb;
        exp_l  = a_big ? ea : eb;
        exp_s  = a_big ? eb : ea;
        sig_l  = a_big ? (a_zero ? '0 : {1'b1, ma, 3'b000})
                       : (b_zero ? '0 : {1'b1, mb, 3'b000});
        sig_s  = a_big ? (b_zero ? '0 : {1'b1, mb, 3'b000})
                       : (a_zero ? '0 : {1'b1, ma, 3'b000});
        diff   = exp_l - exp_s;
        ext    = {sig_s, {SIG_W{1'b0}}} >> diff;
        if (diff >= EXP_W'(SIG_W)) begin
            sig_s_al = {{(SIG_W-1){1'b0}}, |sig_s};
        end else begin
            sig_s_al    = ext[2*SIG_W-1:SIG_W];
            sig_s_al[0] = sig_s_al[0] | (|ext[SIG_W-1:0]);
        end
        any_nan = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
        any_inf = a_inf || b_inf;
    end

    logic             s1_valid, s1_special, s1_invalid, s1_sign, s1_sub;
    logic [W-1:0]     s1_spec_val;
    logic [EXP_W-1:0] s1_exp;
    logic [SIG_W-1:0] s1_sig_l, s1_sig_s;

    // ------------------------------------------------------------------ S2
    logic [SIG_W:0]   add_raw;
    logic [SIG_W-1:0] sub_raw, norm;
    logic [CNT_W-1:0] lz;
    sexp_t            norm_exp;
    logic             norm_sign;

    always_comb begin
        add_raw   = {1'b0, s1_sig_l} + {1'b0, s1_sig_s};
        sub_raw   = s1_sig_l - s1_sig_s;
        lz        = lzc(sub_raw);
        norm_exp  = sexp_t'(s1_exp);
        norm_sign = s1_sign;
        if (!s1_sub) begin
            if (add_raw[SIG_W]) begin
                norm     = add_raw[SIG_W:1];
                norm[0]  = norm[0] | add_raw[0];
                norm_exp = sexp_t'(s1_exp) + sexp_t'(1);
            end else begin
                norm = add_raw[SIG_W-1:0];
            end
        end else begin
            norm     = sub_raw << lz;
            norm_exp = sexp_t'(s1_exp) - sexp_t'(lz);
            // Exact cancellation always yields +0.
            if (sub_raw == '0) norm_sign = 1'b0;
        end
    end

    // A normalised nonzero result always has its hidden bit set, so the
    // hidden bit doubles as the not-zero indicator and need not be stored.
    logic             s2_valid, s2_special, s2_invalid, s2_sign, s2_zero;
    logic [W-1:0]     s2_spec_val;
    sexp_t            s2_exp;
    logic [SIG_W-2:0] s2_frac;

    // ------------------------------------------------------------------ S3
    logic             guard, rnd, stk, inc, carry, inexact;
    logic [MAN_W-1:0] man_r;
    sexp_t            exp_r;
    logic [W-1:0]     res_sum;
    logic [3:0]       res_flags;

    always_comb begin
        guard   = s2_frac[2];
        rnd     = s2_frac[1];
        stk     = s2_frac[0];
        inc     = guard && (rnd || stk || s2_frac[3]);
        inexact = guard || rnd || stk;
        // A carry out of the mantissa means 1.11..1 rounded up to 10.00..0:
        // the mantissa wraps to zero and the exponent takes the carry.
        {carry, man_r} = {1'b0, s2_frac[SIG_W-2:3]} + (MAN_W+1)'(inc);
        exp_r     = s2_exp + sexp_t'(carry);
        res_sum   = {s2_sign, exp_r[EXP_W-1:0], man_r};
        res_flags = {3'b000, inexact};
        if (s2_special) begin
            res_sum   = s2_spec_val;
            res_flags = {s2_invalid, 3'b000};
        end else if (s2_zero) begin
            res_sum   = {s2_sign, {(W-1){1'b0}}};
            res_flags = 4'b0000;
        end else if (exp_r >= sexp_t'(EXP_MAX)) begin
`ifdef FP_ADD_SAT_EN
            res_sum   = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`else
            res_sum   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`endif
            res_flags = 4'b0101;
        end else if (exp_r <= sexp_t'(0)) begin
            res_sum   = {s2_sign, {(W-1){1'b0}}};
            res_flags = 4'b0011;
        end
    end

    // ------------------------------------------------------------- registers
    // NOTE: only the valid bits and the visible outputs are reset; payload
    // registers are qualified by their valid and need no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                sum   <= res_sum;
                flags <= res_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_special  <= any_nan || any_inf;
            s1_invalid  <= any_nan;
            s1_spec_val <= any_nan ? QNAN : (a_inf ? a : b);
            s1_sign     <= sign_l;
            s1_sub      <= (sa != sb);
            s1_exp      <= exp_l;
            s1_sig_l    <= sig_l;
            s1_sig_s    <= sig_s_al;

            s2_special  <= s1_special;
            s2_invalid  <= s1_invalid;
            s2_spec_val <= s1_spec_val;
            s2_sign     <= norm_sign;
            s2_zero     <= !norm[SIG_W-1];
            s2_exp      <= norm_exp;
            s2_frac     <= norm[SIG_W-2:0];
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_add_pipe -- self-checking bench for fp_add_pipe (BF16 default).
// Expected results are pushed to a scoreboard queue when an operand pair is
// accepted and compared when the DUT hands the result over.
// ---------------------------------------------------------------------------
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    logic [19:0] exp_q[$];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic [3:0]  f;
    } vec_t;

`ifdef FP_ADD_SAT_EN
    localparam logic [15:0] POS_OVF = 16'h7F7F;
    localparam logic [15:0] NEG_OVF = 16'hFF7F;
`else
    localparam logic [15:0] POS_OVF = 16'h7F80;
    localparam logic [15:0] NEG_OVF = 16'hFF80;
`endif

    localparam int NV = 16;
    localparam vec_t VECS [NV] = '{
        '{16'h3F80, 16'h4000, 16'h4040, 4'b0000},  // 1 + 2
        '{16'h3F80, 16'h3B80, 16'h3F80, 4'b0001},  // RNE tie to even
        '{16'h3F80, 16'h3BC0, 16'h3F81, 4'b0001},  // above tie
        '{16'h3F80, 16'hBF80, 16'h0000, 4'b0000},  // exact cancellation
        '{16'h7F80, 16'hFF80, 16'h7FC0, 4'b1000},  // inf - inf
        '{16'h7F7F, 16'h7F7F, POS_OVF,  4'b0101},  // overflow
        '{16'hFF7F, 16'hFF7F, NEG_OVF,  4'b0101},  // negative overflow
        '{16'h8000, 16'h8000, 16'h8000, 4'b0000},  // -0 + -0
        '{16'h0000, 16'h8000, 16'h0000, 4'b0000},  // +0 + -0
        '{16'h7F80, 16'h3F80, 16'h7F80, 4'b0000},  // inf + finite
        '{16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000},  // NaN input
        '{16'h3F80, 16'hBF00, 16'h3F00, 4'b0000},  // 1 - 0.5
        '{16'h0080, 16'h80C0, 16'h8000, 4'b0011},  // underflow, sign kept
        '{16'h3F80, 16'h0080, 16'h3F80, 4'b0001},  // huge diff, sticky only
        '{16'h3F80, 16'h8080, 16'h3F80, 4'b0001},  // sticky borrow rounds up
        '{16'h0001, 16'h3F80, 16'h3F80, 4'b0000}   // subnormal flushed
    };

    fp_add_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Scoreboard: a handshake completes at the next rising edge, so sample
    // on the falling edge while everything is stable.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [19:0] e;
            n_tests++;
            n_out++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: sum=%h flags=%b with no result outstanding", sum, flags);
            end else begin
                e = exp_q.pop_front();
                if ({sum, flags} !== e) begin
                    n_fail++;
                    $display("FAIL result: sum=%h flags=%b, expected sum=%h flags=%b",
                             sum, flags, e[19:4], e[3:0]);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the pair is accepted.
    task automatic send(input vec_t v);
        int waited = 0;
        in_valid = 1'b1;
        a = v.a;
        b = v.b;
        #1;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
        end else begin
            exp_q.push_back({v.s, v.f});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            sync();
            cyc++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d results outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || flags !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b sum=%h flags=%b, required 0/0000/0000",
                     out_valid, sum, flags);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        int cyc = 1;
        sync();
        out_ready = 1'b1;
        send(VECS[0]);
        while (!out_valid && cyc < 10) begin
            sync();
            cyc++;
        end
        n_tests++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL latency: out_valid after %0d cycles, required 3", cyc);
        end
        drain("latency");
    endtask

    task automatic test_vectors();
        sync();
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) send(VECS[i]);
        drain("vectors");
    endtask

    task automatic test_back_to_back();
        int          n0;
        int          stall_bad = 0;
        logic [15:0] held_s;
        logic [3:0]  held_f;
        sync();
        out_ready = 1'b1;
        n0 = n_out;
        fork
            begin
                send(VECS[0]);
                send(VECS[1]);
                send(VECS[2]);
                send(VECS[11]);
                send(VECS[13]);
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    if (c == 4) begin
                        out_ready = 1'b0;
                        #1;
                        held_s = sum;
                        held_f = flags;
                    end else if (c == 9) begin
                        out_ready = 1'b1;
                    end else if (c > 4) begin
                        #1;
                        if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                            sum !== held_s || flags !== held_f) stall_bad++;
                    end
                    sync();
                end
            end
        join
        n_tests++;
        if (stall_bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d stalled cycles with in_ready high or output changed, required 0",
                     stall_bad);
        end
        drain("back_to_back");
        n_tests++;
        if (n_out - n0 != 5) begin
            n_fail++;
            $display("FAIL stream_count: %0d results delivered, required 5", n_out - n0);
        end
    endtask

    task automatic test_reset_in_flight();
        int stale = 0;
        sync();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 16'h3F80;
        b = 16'h4000;
        sync();
        a = 16'h3F80;
        b = 16'h3BC0;
        sync();
        in_valid = 1'b0;
        sync();
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL in_flight_valid: out_valid=%b, required 1 before reset", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b, required 0", out_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            sync();
            if (out_valid) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL stale_result: out_valid high in %0d cycles after reset, required 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_in_flight();
        test_vectors();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
